// File: rtl/vote_display_pkg.sv
// Shared types and constants for the vote tally display.
//   state_t           : tally FSM states
//   SEG_0..SEG_9      : active-high segment patterns {a,b,c,d,e,f,g}, seg[6]=a
//   SEG_DASH/SEG_BLANK: g-only dash and all-off blank
//   CODE_DASH/BLANK   : encoder input codes for the two non-digit glyphs
package vote_display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LATCH = 2'd1,
      COUNT = 2'd2,
      SHOW  = 2'd3
   } state_t;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_DASH  = 7'b0000001;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [3:0] CODE_DASH  = 4'hE;
   localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational glyph encoder: 0-9 -> digit, 4'hE -> dash, anything else -> blank.
//   code  : 4-bit glyph code
//   seg_c : active-high segments {a,b,c,d,e,f,g}
module seg7_encoder
   import vote_display_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      case (code)
         4'd0:      seg_c = SEG_0;
         4'd1:      seg_c = SEG_1;
         4'd2:      seg_c = SEG_2;
         4'd3:      seg_c = SEG_3;
         4'd4:      seg_c = SEG_4;
         4'd5:      seg_c = SEG_5;
         4'd6:      seg_c = SEG_6;
         4'd7:      seg_c = SEG_7;
         4'd8:      seg_c = SEG_8;
         4'd9:      seg_c = SEG_9;
         CODE_DASH: seg_c = SEG_DASH;
         default:   seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/vote_tally_display.sv
// Samples a bank of voter switches on a strobe, counts yes votes, flags majority/tie
// and drives a time-multiplexed 7-segment display.
//   clk, rst : clock, synchronous active-high reset
//   votes    : voter switches (1 = yes), sample: capture strobe, clear: back to idle
//   seg, an  : registered segments / one-hot digit enables, polarity per ACTIVE_LOW
//   count, valid, majority, tie : registered tally results
module vote_tally_display
   import vote_display_pkg::*;
#(
   parameter int unsigned N_VOTERS    = 5,
   parameter int unsigned N_DIGITS    = 2,
   parameter int unsigned REFRESH_DIV = 1000,
   parameter bit          ACTIVE_LOW  = 1'b1
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic [N_VOTERS-1:0]             votes,
   input  logic                            sample,
   input  logic                            clear,
   output logic [6:0]                      seg,
   output logic [N_DIGITS-1:0]             an,
   output logic [$clog2(N_VOTERS+1)-1:0]   count,
   output logic                            valid,
   output logic                            majority,
   output logic                            tie
);

   localparam int unsigned CW = $clog2(N_VOTERS + 1);
   localparam int unsigned RW = $clog2(REFRESH_DIV);
   localparam int unsigned DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   state_t              state, state_nx;
   logic [N_VOTERS-1:0] vote_reg;
   logic [CW-1:0]       pop_c;
   logic                majority_c, tie_c;
   logic [RW-1:0]       refresh_cnt;
   logic [DW-1:0]       digit_idx;
   logic [31:0]         count_w;
   logic [3:0]          ones_c, tens_c, code_c;
   logic [6:0]          seg_c;
   logic [N_DIGITS-1:0] an_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state: clear beats sample, sample restarts from any state
   always_comb begin
      state_nx = state;
      if (clear) begin
         state_nx = IDLE;
      end else if (sample) begin
         state_nx = LATCH;
      end else begin
         case (state)
            LATCH:   state_nx = COUNT;
            COUNT:   state_nx = SHOW;
            default: state_nx = state;
         endcase
      end
   end

   // Yes-vote popcount and flags from the latched votes
   always_comb begin
      pop_c = '0;
      for (int unsigned i = 0; i < N_VOTERS; i++)
         pop_c = pop_c + CW'(vote_reg[i]);
      majority_c = (32'(pop_c) > (N_VOTERS / 2));
      tie_c      = ((N_VOTERS % 2) == 0) && (32'(pop_c) == (N_VOTERS / 2));
   end

   // Vote capture, tally registers and valid flag
   always_ff @(posedge clk) begin
      if (rst) begin
         vote_reg <= '0;
         count    <= '0;
         valid    <= 1'b0;
         majority <= 1'b0;
         tie      <= 1'b0;
      end else if (clear) begin
         count    <= '0;
         valid    <= 1'b0;
         majority <= 1'b0;
         tie      <= 1'b0;
      end else if (sample) begin
         vote_reg <= votes;
         valid    <= 1'b0;
      end else begin
         if (state == COUNT) begin
            count    <= pop_c;
            majority <= majority_c;
            tie      <= tie_c;
         end
         if (state == SHOW) valid <= 1'b1;
      end
   end

   // Free-running refresh divider and digit index
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
      end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
         refresh_cnt <= '0;
         digit_idx   <= (digit_idx == DW'(N_DIGITS - 1)) ? '0 : digit_idx + DW'(1);
      end else begin
         refresh_cnt <= refresh_cnt + RW'(1);
      end
   end

   // Glyph selection: decimal split in SHOW (leading-zero tens blanked), dashes otherwise
   always_comb begin
      count_w = 32'(count);
      ones_c  = 4'(count_w % 32'd10);
      tens_c  = 4'(count_w / 32'd10);
      code_c  = CODE_DASH;
      if (state == SHOW) begin
         if (digit_idx == '0)
            code_c = ones_c;
         else if ((digit_idx == DW'(1)) && (tens_c != 4'd0))
            code_c = tens_c;
         else
            code_c = CODE_BLANK;
      end
      an_c = N_DIGITS'(1) << digit_idx;
   end

   seg7_encoder u_enc (
      .code  (code_c),
      .seg_c (seg_c)
   );

   // Output registers with polarity applied
   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= ACTIVE_LOW ? ~SEG_DASH : SEG_DASH;
         an  <= ACTIVE_LOW ? ~N_DIGITS'(1) : N_DIGITS'(1);
      end else begin
         seg <= ACTIVE_LOW ? ~seg_c : seg_c;
         an  <= ACTIVE_LOW ? ~an_c : an_c;
      end
   end

endmodule

// File: tb/tb_vote_tally_display.sv
// Bench for vote_tally_display: three instances (5, 6 and 12 voters, mixed polarity)
// share one stimulus bus; a scoreboard queue holds the expected tally of the pending sample.
module tb_vote_tally_display;

   logic        clk = 1'b0;
   logic        rst, sample, clear;
   logic [11:0] vbus;

   logic [6:0] seg5, seg6, seg12;
   logic [1:0] an5, an6;
   logic [2:0] an12;
   logic [2:0] count5, count6;
   logic [3:0] count12;
   logic       valid5, valid6, valid12;
   logic       maj5, maj6, maj12, tie5, tie6, tie12;

   int checks   = 0;
   int failures = 0;

   typedef struct { int c5; int c6; int c12; } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   vote_tally_display #(.N_VOTERS(5), .N_DIGITS(2), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) d5 (
      .clk(clk), .rst(rst), .votes(vbus[4:0]), .sample(sample), .clear(clear),
      .seg(seg5), .an(an5), .count(count5), .valid(valid5), .majority(maj5), .tie(tie5));

   vote_tally_display #(.N_VOTERS(6), .N_DIGITS(2), .REFRESH_DIV(3), .ACTIVE_LOW(1'b0)) d6 (
      .clk(clk), .rst(rst), .votes(vbus[5:0]), .sample(sample), .clear(clear),
      .seg(seg6), .an(an6), .count(count6), .valid(valid6), .majority(maj6), .tie(tie6));

   vote_tally_display #(.N_VOTERS(12), .N_DIGITS(3), .REFRESH_DIV(5), .ACTIVE_LOW(1'b1)) d12 (
      .clk(clk), .rst(rst), .votes(vbus[11:0]), .sample(sample), .clear(clear),
      .seg(seg12), .an(an12), .count(count12), .valid(valid12), .majority(maj12), .tie(tie12));

   // Reference glyphs {a,b,c,d,e,f,g}; 10 = dash, 11 = blank
   function automatic logic [6:0] ref_seg(input int d);
      case (d)
         0:  return 7'b1111110;
         1:  return 7'b0110000;
         2:  return 7'b1101101;
         3:  return 7'b1111001;
         4:  return 7'b0110011;
         5:  return 7'b1011011;
         6:  return 7'b1011111;
         7:  return 7'b1110000;
         8:  return 7'b1111111;
         9:  return 7'b1111011;
         10: return 7'b0000001;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic int popc(input logic [11:0] v, input int n);
      int r = 0;
      for (int i = 0; i < n; i++) r += int'(v[i]);
      return r;
   endfunction

   function automatic logic f_maj(input int c, input int n);
      return c > n / 2;
   endfunction

   function automatic logic f_tie(input int c, input int n);
      return (n % 2 == 0) && (c == n / 2);
   endfunction

   // Active-high views of each instance's display outputs
   function automatic logic [6:0] seg_n(input int sel);
      case (sel)
         0:       return ~seg5;
         1:       return seg6;
         default: return ~seg12;
      endcase
   endfunction

   function automatic logic [2:0] an_n(input int sel);
      case (sel)
         0:       return {1'b0, ~an5};
         1:       return {1'b0, an6};
         default: return ~an12;
      endcase
   endfunction

   // Scoreboard: pop and compare on every rising edge of valid
   logic v5_q = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         v5_q = 1'b0;
      end else begin
         if (valid5 && !v5_q) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected_valid: valid rose with count5=%0d and nothing pending", count5);
            end else begin
               e = sb.pop_front();
               if ({count5, maj5, tie5} !== {3'(e.c5), f_maj(e.c5, 5), f_tie(e.c5, 5)}) begin
                  failures++;
                  $display("FAIL sb_n5: got count=%0d maj=%b tie=%b expected count=%0d maj=%b tie=%b",
                           count5, maj5, tie5, e.c5, f_maj(e.c5, 5), f_tie(e.c5, 5));
               end
               checks++;
               if ({valid6, count6, maj6, tie6} !== {1'b1, 3'(e.c6), f_maj(e.c6, 6), f_tie(e.c6, 6)}) begin
                  failures++;
                  $display("FAIL sb_n6: got valid=%b count=%0d maj=%b tie=%b expected 1 count=%0d maj=%b tie=%b",
                           valid6, count6, maj6, tie6, e.c6, f_maj(e.c6, 6), f_tie(e.c6, 6));
               end
               checks++;
               if ({valid12, count12, maj12, tie12} !== {1'b1, 4'(e.c12), f_maj(e.c12, 12), f_tie(e.c12, 12)}) begin
                  failures++;
                  $display("FAIL sb_n12: got valid=%b count=%0d maj=%b tie=%b expected 1 count=%0d maj=%b tie=%b",
                           valid12, count12, maj12, tie12, e.c12, f_maj(e.c12, 12), f_tie(e.c12, 12));
               end
            end
         end
         v5_q = valid5;
      end
   end

   // Strobe sample for one cycle; returns 1ns after the capturing edge
   task automatic do_sample(input logic [11:0] v, input bit push);
      exp_t e;
      @(posedge clk);
      #1;
      vbus   = v;
      sample = 1'b1;
      sb.delete();
      if (push) begin
         e.c5  = popc(v, 5);
         e.c6  = popc(v, 6);
         e.c12 = popc(v, 12);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      sample = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!valid5 && n < 12);
      checks++;
      if (valid5 !== 1'b1) begin
         failures++;
         $display("FAIL %s_valid_timeout: valid=%b after %0d cycles, expected 1", name, valid5, n);
      end
   endtask

   task automatic wait_digit(input int sel, input int d, output logic [6:0] s, output bit ok);
      ok = 1'b0;
      s  = 7'bx;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (an_n(sel) === 3'(1 << d)) begin
            s  = seg_n(sel);
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [6:0] s;
      bit ok;
      rst = 1'b1; sample = 1'b0; clear = 1'b0; vbus = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({valid5, valid6, valid12} !== 3'b000) begin
         failures++;
         $display("FAIL reset_valid: got %b expected 000", {valid5, valid6, valid12});
      end
      checks++;
      if ({count5, count6, count12} !== 10'd0) begin
         failures++;
         $display("FAIL reset_count: got %0d/%0d/%0d expected 0/0/0", count5, count6, count12);
      end
      checks++;
      if ({seg_n(0), seg_n(1), seg_n(2)} !== {3{ref_seg(10)}}) begin
         failures++;
         $display("FAIL reset_seg: got %b %b %b expected dash", seg_n(0), seg_n(1), seg_n(2));
      end
      checks++;
      if ({an_n(0), an_n(1), an_n(2)} !== {3'b001, 3'b001, 3'b001}) begin
         failures++;
         $display("FAIL reset_an: got %b %b %b expected 001 each", an_n(0), an_n(1), an_n(2));
      end
      wait_digit(2, 2, s, ok);
      checks++;
      if (!ok || s !== ref_seg(10)) begin
         failures++;
         $display("FAIL reset_dash_d12_dig2: got %b found=%0d expected %b", s, ok, ref_seg(10));
      end
      wait_digit(1, 1, s, ok);
      checks++;
      if (!ok || s !== ref_seg(10)) begin
         failures++;
         $display("FAIL reset_dash_d6_dig1: got %b found=%0d expected %b", s, ok, ref_seg(10));
      end
   endtask

   task automatic test_n5_latency();
      logic [6:0] s;
      bit ok;
      do_sample(12'b0000_0001_0110, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if ({valid5, count5} !== {1'b0, 3'd3}) begin
         failures++;
         $display("FAIL n5_edge_k2: got valid=%b count=%0d expected valid=0 count=3", valid5, count5);
      end
      @(posedge clk);
      #1;
      checks++;
      if (valid5 !== 1'b1) begin
         failures++;
         $display("FAIL n5_edge_k3: got valid=%b expected 1", valid5);
      end
      wait_digit(0, 0, s, ok);
      checks++;
      if (!ok || s !== ref_seg(3)) begin
         failures++;
         $display("FAIL n5_digit0: got %b found=%0d expected %b", s, ok, ref_seg(3));
      end
      wait_digit(0, 1, s, ok);
      checks++;
      if (!ok || s !== ref_seg(11)) begin
         failures++;
         $display("FAIL n5_digit1: got %b found=%0d expected blank", s, ok);
      end
   endtask

   task automatic test_n6_tie_zero();
      logic [6:0] s;
      bit ok;
      do_sample(12'b0000_0000_0111, 1'b1);
      wait_valid("n6_tie");
      checks++;
      if ({tie6, maj6} !== 2'b10) begin
         failures++;
         $display("FAIL n6_tie_flags: got tie=%b maj=%b expected tie=1 maj=0", tie6, maj6);
      end
      do_sample(12'h000, 1'b1);
      wait_valid("n6_zero");
      wait_digit(1, 0, s, ok);
      checks++;
      if (!ok || s !== ref_seg(0)) begin
         failures++;
         $display("FAIL n6_zero_digit0: got %b found=%0d expected %b", s, ok, ref_seg(0));
      end
      wait_digit(1, 1, s, ok);
      checks++;
      if (!ok || s !== ref_seg(11)) begin
         failures++;
         $display("FAIL n6_zero_digit1: got %b found=%0d expected blank", s, ok);
      end
   endtask

   task automatic test_n12_digits();
      logic [6:0] s;
      bit ok;
      int n, period;
      do_sample(12'hFFF, 1'b1);
      wait_valid("n12");
      wait_digit(2, 0, s, ok);
      checks++;
      if (!ok || s !== ref_seg(2)) begin
         failures++;
         $display("FAIL n12_digit0: got %b found=%0d expected %b", s, ok, ref_seg(2));
      end
      wait_digit(2, 1, s, ok);
      checks++;
      if (!ok || s !== ref_seg(1)) begin
         failures++;
         $display("FAIL n12_digit1: got %b found=%0d expected %b", s, ok, ref_seg(1));
      end
      wait_digit(2, 2, s, ok);
      checks++;
      if (!ok || s !== ref_seg(11)) begin
         failures++;
         $display("FAIL n12_digit2: got %b found=%0d expected blank", s, ok);
      end
      // Rotation period: distance between successive entries into digit 0
      n = 0;
      do begin @(negedge clk); n++; end while (an_n(2) === 3'b001 && n < 60);
      n = 0;
      do begin @(negedge clk); n++; end while (an_n(2) !== 3'b001 && n < 60);
      period = 0;
      do begin @(negedge clk); period++; end while (an_n(2) === 3'b001 && period < 60);
      do begin @(negedge clk); period++; end while (an_n(2) !== 3'b001 && period < 60);
      checks++;
      if (period != 15) begin
         failures++;
         $display("FAIL n12_an_period: got %0d cycles expected 15", period);
      end
   endtask

   task automatic test_resample();
      do_sample(12'h3FF, 1'b1);
      checks++;
      if (valid5 !== 1'b0) begin
         failures++;
         $display("FAIL resample_valid_drop: got %b expected 0", valid5);
      end
      do_sample(12'b0000_0000_0001, 1'b1);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (valid5 !== 1'b0) begin
            failures++;
            $display("FAIL resample_valid_low_%0d: got %b expected 0", i, valid5);
         end
      end
      wait_valid("resample");
   endtask

   task automatic test_clear_rst();
      logic [6:0] s;
      bit ok;
      @(posedge clk);
      #1;
      vbus = 12'hFFF; sample = 1'b1; clear = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      sample = 1'b0; clear = 1'b0;
      checks++;
      if ({valid5, count5, maj5, count12} !== {1'b0, 3'd0, 1'b0, 4'd0}) begin
         failures++;
         $display("FAIL clear_regs: got valid=%b count5=%0d maj5=%b count12=%0d expected 0/0/0/0",
                  valid5, count5, maj5, count12);
      end
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if ({valid5, count5} !== {1'b0, 3'd0}) begin
         failures++;
         $display("FAIL clear_sample_ignored: got valid=%b count=%0d expected 0/0", valid5, count5);
      end
      wait_digit(0, 0, s, ok);
      checks++;
      if (!ok || s !== ref_seg(10)) begin
         failures++;
         $display("FAIL clear_dash: got %b found=%0d expected %b", s, ok, ref_seg(10));
      end
      // Reset while in LATCH must discard the captured sample
      do_sample(12'hFFF, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if ({valid5, count5, valid12, count12} !== {1'b0, 3'd0, 1'b0, 4'd0}) begin
         failures++;
         $display("FAIL rst_discard: got valid5=%b count5=%0d valid12=%b count12=%0d expected zeros",
                  valid5, count5, valid12, count12);
      end
      wait_digit(2, 1, s, ok);
      checks++;
      if (!ok || s !== ref_seg(10)) begin
         failures++;
         $display("FAIL rst_dash: got %b found=%0d expected %b", s, ok, ref_seg(10));
      end
   endtask

   initial begin
      rst = 1'b1; sample = 1'b0; clear = 1'b0; vbus = '0;
      test_reset();
      test_n5_latency();
      test_n6_tie_zero();
      test_n12_digits();
      test_resample();
      test_clear_rst();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: %0d expected results never produced, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
